// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART blocks.
// UART_TX_PARITY_EN selects the even-parity frame format.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'h0;
    localparam logic [2:0] STATUS_OFS = 3'h4;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_PARITY = 4;
    localparam int ST_COUNT  = 8;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, TX FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        tx,
    output logic        sel
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          ovf_q;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    logic          is_txdata;
    logic          is_status;
    logic          wr_txdata;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bus_bits;

    assign sel       = (dataAddr[31:3] == BASE_ADDR[31:3]);
    assign is_txdata = ({dataAddr[2], 2'b00} == TXDATA_OFS);
    assign is_status = ({dataAddr[2], 2'b00} == STATUS_OFS);
    assign wr_txdata = sel && we && is_txdata;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign tx        = tx_q;

    assign unused_bus_bits = ^{dataAddr[1:0], writeData[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_txdata),
        .pop_i   (fifo_pop),
        .din_i   (writeData[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status            = '0;
        status[ST_EMPTY]  = fifo_empty;
        status[ST_FULL]   = fifo_full;
        status[ST_BUSY]   = (state_q != IDLE);
        status[ST_OVF]    = ovf_q;
        status[ST_PARITY] = PARITY_EN;
        status[ST_COUNT +: 8] = 8'(fifo_count);
    end

    always_comb begin
        readData = 32'h0;
        if (sel && is_status) begin
            readData = status;
        end
    end

    // Full is sampled before the edge, so a same-cycle pop never rescues the byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (sel && we && is_status && writeData[ST_OVF]) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shreg_q <= fifo_dout;
                        baud_q  <= BAUD_MAX;
                        tx_q    <= 1'b0;
                        state_q <= START;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^fifo_dout;
`endif
                    end
                end
                START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_MAX;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_MAX;
                        shreg_q <= shreg_q >> 1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_MAX;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
